hc_sr04_axil_slave: RTL and testbench

- AXI4-Lite responder that owns the HC-SR04 ultrasonic sensor. It is the slave end of the bus that the AXI VIP master drives in the IP's bfm_design bench.
- Exposes control, status, echo-width and scratch registers.
- Generates the sensor TRIG pulse and measures ECHO high time in ACLK cycles, with timeout, holdoff and a level interrupt.

---
 rtl/hc_sr04_axil_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_hc_sr04_axil_slave.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_sr04_axil_slave.sv
// HC-SR04 ultrasonic ranger behind an AXI4-Lite register slave.
// Registers: 0x0 CTRL, 0x4 STATUS, 0x8 ECHO_CNT, 0xC SCRATCH.
module hc_sr04_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int TRIG_CYCLES        = 1000,
  parameter int TIMEOUT_CYCLES     = 3000000,
  parameter int HOLDOFF_CYCLES     = 6000000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            trig,
  input  logic                            echo,
  output logic                            irq
);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TOUT_MAX  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] echo_cnt_q, echo_cnt_d;
  logic [31:0] scratch_q, rdata_q, rd_mux;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic        cont_q, irqen_q, done_q, tout_q, irq_q, trig_q;
  logic [1:0]  sync_q;
  logic        echo_prev_q;
  logic        wr_fire, rd_fire, start_wr, clr_done, clr_tout, set_done, set_tout;
  logic        echo_s, echo_rise, busy;
  logic [1:0]  wsel, rsel;
  logic        unused_ok;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wsel      = S_AXI_AWADDR[3:2];
  assign rsel      = S_AXI_ARADDR[3:2];
  assign wr_fire   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire   = arready_q & S_AXI_ARVALID;
  assign start_wr  = wr_fire & (wsel == 2'd0) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign clr_done  = wr_fire & (wsel == 2'd1) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];
  assign clr_tout  = wr_fire & (wsel == 2'd1) & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
  assign echo_s    = sync_q[1];
  assign echo_rise = echo_s & ~echo_prev_q;
  assign busy      = (state_q != S_IDLE);

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign trig          = trig_q;
  assign irq           = irq_q;

  // Read mux; START is a pulse so CTRL bit0 always reads back 0.
  always_comb begin
    rd_mux = '0;
    case (rsel)
      2'd0: rd_mux = {29'd0, irqen_q, cont_q, 1'b0};
      2'd1: rd_mux = {29'd0, tout_q, done_q, busy};
      2'd2: rd_mux = echo_cnt_q;
      default: rd_mux = scratch_q;
    endcase
  end

  // AXI handshakes: one-cycle ready pulses, response held until the master takes it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= ~awready_q & ~bvalid_q & S_AXI_AWVALID & S_AXI_WVALID;
      if (wr_fire)           bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      arready_q <= ~arready_q & ~rvalid_q & S_AXI_ARVALID;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Control/scratch registers and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cont_q    <= 1'b0;
      irqen_q   <= 1'b0;
      scratch_q <= '0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      irq_q     <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      if (wr_fire && wsel == 2'd0 && S_AXI_WSTRB[0]) begin
        cont_q  <= S_AXI_WDATA[1];
        irqen_q <= S_AXI_WDATA[2];
      end
      if (wr_fire && wsel == 2'd3) begin
        for (int b = 0; b < 4; b++)
          if (S_AXI_WSTRB[b]) scratch_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
      done_q <= set_done | (done_q & ~clr_done);
      tout_q <= set_tout | (tout_q & ~clr_tout);
      irq_q  <= irqen_q & done_q;
      trig_q <= (state_d == S_TRIG);
    end
  end

  // Two-flop synchronizer on the asynchronous echo, plus edge history.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync_q      <= 2'b00;
      echo_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], echo};
      echo_prev_q <= echo_s;
    end
  end

  // Measurement FSM state, shared phase counter and latched result.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      echo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      echo_cnt_q <= echo_cnt_d;
    end
  end

  // Next-state: one counter times each phase and saturates at the timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    echo_cnt_d = echo_cnt_q;
    set_done   = 1'b0;
    set_tout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_wr || cont_q) begin
          state_d = S_TRIG;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = S_MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q == TOUT_LAST) begin
          state_d    = S_HOLDOFF;
          cnt_d      = '0;
          echo_cnt_d = '1;
          set_done   = 1'b1;
          set_tout   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MEASURE: begin
        if (!echo_s) begin
          state_d    = S_HOLDOFF;
          cnt_d      = '0;
          echo_cnt_d = cnt_q;
          set_done   = 1'b1;
        end else if (cnt_q == TOUT_MAX) begin
          state_d    = S_HOLDOFF;
          cnt_d      = '0;
          echo_cnt_d = '1;
          set_done   = 1'b1;
          set_tout   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_hc_sr04_axil_slave.sv
// Scoreboard bench for hc_sr04_axil_slave with shortened timing parameters.
module tb_hc_sr04_axil_slave;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        trig;
  logic        echo = 1'b0;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  string       rn[$];

  hc_sr04_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
    .TRIG_CYCLES(10), .TIMEOUT_CYCLES(1000), .HOLDOFF_CYCLES(20)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .trig(trig), .echo(echo), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response handshake is about to complete.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected: got bresp 0x%0h with nothing expected", S_AXI_BRESP);
        end else begin
          chk("bresp", 32'(S_AXI_BRESP), 32'(bq.pop_front()));
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL r_unexpected: got rdata 0x%08h with nothing expected", S_AXI_RDATA);
        end else begin
          string nm;
          nm = rn.pop_front();
          chk(nm, S_AXI_RDATA, rq.pop_front());
          chk({nm, "_rresp"}, 32'(S_AXI_RRESP), 32'd0);
        end
      end
    end
  end

  task automatic aw_start(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    bq.push_back(2'b00);
  endtask

  task automatic aw_finish();
    int n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!S_AXI_AWREADY) begin
      n_chk++; n_fail++;
      $display("FAIL aw_timeout: awready 0 after %0d cycles, required 1", n);
    end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    aw_start(a, d, s);
    aw_finish();
  endtask

  task automatic ar_start(input logic [3:0] a, input logic [31:0] e, input string nm);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    rq.push_back(e); rn.push_back(nm);
  endtask

  task automatic ar_finish();
    int n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!S_AXI_ARREADY) begin
      n_chk++; n_fail++;
      $display("FAIL ar_timeout: arready 0 after %0d cycles, required 1", n);
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] e, input string nm);
    int n = 0;
    ar_start(a, e, nm);
    ar_finish();
    while (S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
  endtask

  // Ready changes land mid-high-phase so the monitor sees them before the next edge.
  task automatic set_bready(input logic v);
    @(posedge ACLK); #2 S_AXI_BREADY = v; @(negedge ACLK);
  endtask

  task automatic set_rready(input logic v);
    @(posedge ACLK); #2 S_AXI_RREADY = v; @(negedge ACLK);
  endtask

  task automatic trig_pulse(input int budget, output int width);
    int n = 0;
    width = 0;
    while (!trig && n < budget) begin @(negedge ACLK); n++; end
    while (trig && width < 100) begin width++; @(negedge ACLK); end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, cnt;
    logic ok;
    logic [31:0] d0;

    repeat (3) @(negedge ACLK);
    chk("reset_outputs", {26'd0, trig, irq, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY}, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // 1: reset values, byte strobes, address aliasing, read-only register
    axi_read(4'h0, 32'h0, "rst_ctrl");
    axi_read(4'h4, 32'h0, "rst_status");
    axi_read(4'h8, 32'h0, "rst_echo");
    axi_read(4'hC, 32'h0, "rst_scratch");
    axi_write(4'hC, 32'hA5A5A5A5, 4'h3);
    axi_read(4'hC, 32'h0000A5A5, "scratch_strb");
    axi_read(4'hD, 32'h0000A5A5, "scratch_alias");
    axi_write(4'h0, 32'h6, 4'h2);
    axi_read(4'h0, 32'h0, "ctrl_strb_hi");
    axi_write(4'h8, 32'h1234, 4'hF);
    axi_read(4'h8, 32'h0, "echo_ro");

    // 2: single measurement, 250-cycle echo
    axi_write(4'h0, 32'h5, 4'h1);
    trig_pulse(50, w);
    chk("t2_trig_width", 32'(w), 32'd10);
    echo = 1'b1; repeat (250) @(negedge ACLK); echo = 1'b0;
    repeat (40) @(negedge ACLK);
    axi_read(4'h8, 32'd250, "t2_echo_cnt");
    axi_read(4'h4, 32'h2, "t2_status");
    axi_read(4'h0, 32'h4, "t2_ctrl");
    chk("t2_irq_set", 32'(irq), 32'd1);
    axi_write(4'h4, 32'h2, 4'h1);
    repeat (3) @(negedge ACLK);
    axi_read(4'h4, 32'h0, "t2_status_clr");
    chk("t2_irq_clr", 32'(irq), 32'd0);

    // 3: no echo -> rise timeout; START during holdoff ignored
    axi_write(4'h0, 32'h5, 4'h1);
    trig_pulse(50, w);
    chk("t3_trig_width", 32'(w), 32'd10);
    n = 0;
    while (!irq && n < 1200) begin @(negedge ACLK); n++; end
    chk("t3_timeout_cycles", 32'(n), 32'd1001);
    axi_write(4'h0, 32'h5, 4'h1);
    cnt = 0;
    repeat (60) begin if (trig) cnt++; @(negedge ACLK); end
    chk("t3_holdoff_start_ignored", 32'(cnt), 32'd0);
    axi_read(4'h4, 32'h6, "t3_status");
    axi_read(4'h8, 32'hFFFFFFFF, "t3_echo_cnt");

    // 4: echo too long -> width timeout at the counter limit
    axi_write(4'h4, 32'h6, 4'h1);
    axi_write(4'h0, 32'h5, 4'h1);
    trig_pulse(50, w);
    chk("t4_trig_width", 32'(w), 32'd10);
    echo = 1'b1;
    n = 0;
    while (!irq && n < 1200) begin @(negedge ACLK); n++; end
    chk("t4_timeout_cycles", 32'(n), 32'd1004);
    repeat (1500 - n) @(negedge ACLK);
    echo = 1'b0;
    repeat (30) @(negedge ACLK);
    axi_read(4'h4, 32'h6, "t4_status");
    axi_read(4'h8, 32'hFFFFFFFF, "t4_echo_cnt");

    // 5: continuous mode, then clear CONT mid-measurement
    axi_write(4'h4, 32'h6, 4'h1);
    axi_write(4'h0, 32'h2, 4'h1);
    for (int i = 0; i < 2; i++) begin
      trig_pulse(100, w);
      chk("t5_trig_width", 32'(w), 32'd10);
      echo = 1'b1; repeat (100) @(negedge ACLK); echo = 1'b0;
    end
    repeat (10) @(negedge ACLK);
    axi_read(4'h8, 32'd100, "t5_echo_cnt");
    n = 0;
    while (!trig && n < 100) begin @(negedge ACLK); n++; end
    chk("t5_third_trig", 32'(trig), 32'd1);
    axi_write(4'h0, 32'h0, 4'h1);
    n = 0;
    while (trig && n < 50) begin @(negedge ACLK); n++; end
    echo = 1'b1; repeat (120) @(negedge ACLK); echo = 1'b0;
    cnt = 0;
    repeat (80) begin if (trig) cnt++; @(negedge ACLK); end
    chk("t5_stays_idle", 32'(cnt), 32'd0);
    axi_read(4'h8, 32'd120, "t5_last_echo");
    axi_read(4'h4, 32'h2, "t5_status");
    axi_read(4'h0, 32'h0, "t5_ctrl");

    // 6a: write response backpressure
    set_bready(1'b0);
    axi_write(4'hC, 32'h12345678, 4'hF);
    aw_start(4'hC, 32'hDEADBEEF, 4'hF);
    ok = 1'b1;
    repeat (5) begin
      if (!S_AXI_BVALID || S_AXI_AWREADY) ok = 1'b0;
      @(negedge ACLK);
    end
    chk("t6_bvalid_hold", 32'(ok), 32'd1);
    set_bready(1'b1);
    aw_finish();
    axi_read(4'hC, 32'hDEADBEEF, "t6_scratch");

    // 6b: read data backpressure
    set_rready(1'b0);
    ar_start(4'hC, 32'hDEADBEEF, "t6_rd_held");
    ar_finish();
    d0 = S_AXI_RDATA;
    axi_write(4'hC, 32'h0, 4'hF);
    ok = 1'b1;
    repeat (5) begin
      if (!S_AXI_RVALID || S_AXI_RDATA !== d0) ok = 1'b0;
      @(negedge ACLK);
    end
    chk("t6_rdata_stable", 32'(ok), 32'd1);
    set_rready(1'b1);
    @(negedge ACLK);
    axi_read(4'hC, 32'h0, "t6_scratch_after");

    // 6c: reset while the trigger is high
    axi_write(4'hC, 32'h0BADF00D, 4'hF);
    axi_write(4'h0, 32'h5, 4'h1);
    repeat (3) @(negedge ACLK);
    chk("t6_trig_before_rst", 32'(trig), 32'd1);
    #2 ARESETN = 1'b0;
    #1 chk("t6_trig_async_drop", 32'(trig), 32'd0);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    axi_read(4'h0, 32'h0, "t6_rst_ctrl");
    axi_read(4'h4, 32'h0, "t6_rst_status");
    axi_read(4'h8, 32'h0, "t6_rst_echo");
    axi_read(4'hC, 32'h0, "t6_rst_scratch");
    chk("t6_rst_trig_irq", {30'd0, trig, irq}, 32'd0);

    repeat (5) @(negedge ACLK);
    chk("b_queue_empty", 32'(bq.size()), 32'd0);
    chk("r_queue_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
